// File: rtl/pc_file_if.sv
// Fetch-side bundle for pc_file: redirect sources in, fetch PC and mode status out.
// exp_cnt exists only when PC_FILE_EXP_CNT_EN is defined.
interface pc_file_if #(
    parameter int NUM_TRD = 8,
    parameter int PC_W    = 32
);
    localparam int TRD_W = $clog2(NUM_TRD);

    logic [TRD_W-1:0]   fetch_trd;
    logic               i_rd;
    logic               stall;
    logic [PC_W-1:0]    fetch_pc;
    logic               jmp;
    logic [TRD_W-1:0]   jmp_trd;
    logic [PC_W-1:0]    jmp_pc;
    logic               i_miss;
    logic [TRD_W-1:0]   i_miss_trd;
    logic [PC_W-1:0]    i_miss_pc;
    logic               d_miss;
    logic [TRD_W-1:0]   d_miss_trd;
    logic [PC_W-1:0]    d_miss_pc;
    logic               exp;
    logic [TRD_W-1:0]   exp_trd;
    logic [PC_W-1:0]    exp_pc;
    logic               ret;
    logic [TRD_W-1:0]   ret_trd;
    logic [NUM_TRD-1:0] exp_mode;
    logic               exp_drop;
`ifdef PC_FILE_EXP_CNT_EN
    logic [7:0]         exp_cnt;
`endif

    modport master (
        output fetch_trd, i_rd, stall,
               jmp, jmp_trd, jmp_pc,
               i_miss, i_miss_trd, i_miss_pc,
               d_miss, d_miss_trd, d_miss_pc,
               exp, exp_trd, exp_pc,
               ret, ret_trd,
        input  fetch_pc, exp_mode, exp_drop
`ifdef PC_FILE_EXP_CNT_EN
             , exp_cnt
`endif
    );

    modport slave (
        input  fetch_trd, i_rd, stall,
               jmp, jmp_trd, jmp_pc,
               i_miss, i_miss_trd, i_miss_pc,
               d_miss, d_miss_trd, d_miss_pc,
               exp, exp_trd, exp_pc,
               ret, ret_trd,
        output fetch_pc, exp_mode, exp_drop
`ifdef PC_FILE_EXP_CNT_EN
             , exp_cnt
`endif
    );
endinterface

// File: rtl/pc_file.sv
// Per-thread PC / EPC / mode file with prioritised redirects for the barrel-threaded fetch stage.
// Optional per-thread saturating exception counter enabled by PC_FILE_EXP_CNT_EN.
module pc_file #(
    parameter int              NUM_TRD    = 8,
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] START_PC   = '0,
    parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(32'h100),
    parameter int              TRD_W      = $clog2(NUM_TRD)
) (
    input logic    clk,
    input logic    rst,
    pc_file_if.slave bus
);
    typedef enum logic {ST_RUN = 1'b0, ST_EXC = 1'b1} trd_state_e;

    trd_state_e      r_state [NUM_TRD];
    logic [PC_W-1:0] r_pc    [NUM_TRD];
    logic [PC_W-1:0] r_epc   [NUM_TRD];
    logic            r_drop;

    logic [TRD_W-1:0]   w_fetch_trd;
    logic [NUM_TRD-1:0] w_exp_acc, w_ret_acc, w_dm_hit, w_im_hit, w_jmp_hit, w_inc_hit;

    assign w_fetch_trd = bus.fetch_trd;

    // One-hot target decode per source; exp/ret qualified by the target thread's mode.
    always_comb begin
        w_dm_hit  = bus.d_miss ? (NUM_TRD'(1) << bus.d_miss_trd) : '0;
        w_im_hit  = bus.i_miss ? (NUM_TRD'(1) << bus.i_miss_trd) : '0;
        w_jmp_hit = (bus.jmp  && !bus.stall) ? (NUM_TRD'(1) << bus.jmp_trd)   : '0;
        w_inc_hit = (bus.i_rd && !bus.stall) ? (NUM_TRD'(1) << bus.fetch_trd) : '0;
        w_exp_acc = '0;
        w_ret_acc = '0;
        for (int t = 0; t < NUM_TRD; t++) begin
            w_exp_acc[t] = bus.exp && (bus.exp_trd == TRD_W'(t)) && (r_state[t] == ST_RUN);
            w_ret_acc[t] = bus.ret && (bus.ret_trd == TRD_W'(t)) && (r_state[t] == ST_EXC);
        end
    end

    // NOTE: the register arrays sit on the async reset because every PC must read START_PC
    // the instant rst rises; this is flop storage, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_TRD; t++) begin
                r_state[t] <= ST_RUN;
                r_pc[t]    <= START_PC;
                r_epc[t]   <= START_PC;
            end
            r_drop <= 1'b0;
        end else begin
            for (int t = 0; t < NUM_TRD; t++) begin
                if (w_exp_acc[t]) begin
                    r_pc[t]    <= HANDLER_PC;
                    r_epc[t]   <= bus.exp_pc;
                    r_state[t] <= ST_EXC;
                end else if (w_ret_acc[t]) begin
                    r_pc[t]    <= r_epc[t];
                    r_state[t] <= ST_RUN;
                end else if (w_dm_hit[t]) begin
                    r_pc[t] <= bus.d_miss_pc;
                end else if (w_im_hit[t]) begin
                    r_pc[t] <= bus.i_miss_pc;
                end else if (w_jmp_hit[t]) begin
                    r_pc[t] <= bus.jmp_pc;
                end else if (w_inc_hit[t]) begin
                    r_pc[t] <= r_pc[t] + PC_W'(1);
                end
            end
            r_drop <= bus.exp && (r_state[bus.exp_trd] == ST_EXC);
        end
    end

    assign bus.fetch_pc = r_pc[w_fetch_trd];
    assign bus.exp_drop = r_drop;

    always_comb begin
        bus.exp_mode = '0;
        for (int t = 0; t < NUM_TRD; t++) begin
            bus.exp_mode[t] = (r_state[t] == ST_EXC);
        end
    end

`ifdef PC_FILE_EXP_CNT_EN
    logic [7:0] r_cnt [NUM_TRD];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_TRD; t++) r_cnt[t] <= '0;
        end else begin
            for (int t = 0; t < NUM_TRD; t++) begin
                if (w_exp_acc[t]) begin
                    if (r_cnt[t] != 8'hFF) r_cnt[t] <= r_cnt[t] + 8'd1;
                end else if (w_ret_acc[t]) begin
                    r_cnt[t] <= '0;
                end
            end
        end
    end

    assign bus.exp_cnt = r_cnt[w_fetch_trd];
`endif
endmodule

// File: tb/tb_pc_file.sv
// Directed bench for pc_file: event-ordered reference model checked every cycle, plus literal pins.
// Define PC_FILE_EXP_CNT_EN to also exercise the exception counter.
module tb_pc_file;
    localparam int N  = 8;
    localparam int W  = 32;
    localparam int TW = 3;
    localparam logic [W-1:0] START   = 32'h0;
    localparam logic [W-1:0] HANDLER = 32'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pc_file_if #(.NUM_TRD(N), .PC_W(W)) bus ();

    pc_file #(.NUM_TRD(N), .PC_W(W), .START_PC(START), .HANDLER_PC(HANDLER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference model: the cycle's events are applied in priority order; each thread takes at most one write.
    logic [W-1:0] m_pc  [N];
    logic [W-1:0] m_epc [N];
    logic [7:0]   m_cnt [N];
    logic [N-1:0] m_mode;
    logic         m_drop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pc[i] = START; m_epc[i] = START; m_cnt[i] = 8'd0;
            end
            m_mode = '0;
            m_drop = 1'b0;
        end else begin
            bit [N-1:0] taken;
            taken  = '0;
            m_drop = 1'b0;
            if (bus.exp) begin
                if (m_mode[bus.exp_trd]) m_drop = 1'b1;
                else begin
                    m_epc[bus.exp_trd] = bus.exp_pc;
                    m_pc[bus.exp_trd]  = HANDLER;
                    m_mode[bus.exp_trd] = 1'b1;
                    if (m_cnt[bus.exp_trd] != 8'd255) m_cnt[bus.exp_trd] = m_cnt[bus.exp_trd] + 8'd1;
                    taken[bus.exp_trd] = 1'b1;
                end
            end
            if (bus.ret && !taken[bus.ret_trd] && m_mode[bus.ret_trd]) begin
                m_pc[bus.ret_trd]   = m_epc[bus.ret_trd];
                m_mode[bus.ret_trd] = 1'b0;
                m_cnt[bus.ret_trd]  = 8'd0;
                taken[bus.ret_trd]  = 1'b1;
            end
            if (bus.d_miss && !taken[bus.d_miss_trd]) begin
                m_pc[bus.d_miss_trd] = bus.d_miss_pc; taken[bus.d_miss_trd] = 1'b1;
            end
            if (bus.i_miss && !taken[bus.i_miss_trd]) begin
                m_pc[bus.i_miss_trd] = bus.i_miss_pc; taken[bus.i_miss_trd] = 1'b1;
            end
            if (bus.jmp && !bus.stall && !taken[bus.jmp_trd]) begin
                m_pc[bus.jmp_trd] = bus.jmp_pc; taken[bus.jmp_trd] = 1'b1;
            end
            if (bus.i_rd && !bus.stall && !taken[bus.fetch_trd])
                m_pc[bus.fetch_trd] = m_pc[bus.fetch_trd] + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_fetch_pc", 64'(bus.fetch_pc), 64'(m_pc[bus.fetch_trd]));
            check("cyc_exp_mode", 64'(bus.exp_mode), 64'(m_mode));
            check("cyc_exp_drop", 64'(bus.exp_drop), 64'(m_drop));
`ifdef PC_FILE_EXP_CNT_EN
            check("cyc_exp_cnt", 64'(bus.exp_cnt), 64'(m_cnt[bus.fetch_trd]));
`endif
        end
    end

    task automatic idle();
        bus.i_rd = 1'b0; bus.stall = 1'b0;
        bus.jmp = 1'b0; bus.jmp_trd = '0; bus.jmp_pc = '0;
        bus.i_miss = 1'b0; bus.i_miss_trd = '0; bus.i_miss_pc = '0;
        bus.d_miss = 1'b0; bus.d_miss_trd = '0; bus.d_miss_pc = '0;
        bus.exp = 1'b0; bus.exp_trd = '0; bus.exp_pc = '0;
        bus.ret = 1'b0; bus.ret_trd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input int t);
        bus.fetch_trd = TW'(t);
        #1;
    endtask

    initial begin
        idle();
        bus.fetch_trd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        peek(3);
        check("rst_pc3", 64'(bus.fetch_pc), 64'h0);
        check("rst_mode", 64'(bus.exp_mode), 64'h0);
        check("rst_drop", 64'(bus.exp_drop), 64'h0);

        bus.i_rd = 1'b1;
        check("inc_0", 64'(bus.fetch_pc), 64'h0);
        tick();
        check("inc_1", 64'(bus.fetch_pc), 64'h1);
        tick();
        check("inc_2", 64'(bus.fetch_pc), 64'h2);
        bus.i_rd = 1'b0;
        peek(2); check("inc_other2", 64'(bus.fetch_pc), 64'h0);
        peek(7); check("inc_other7", 64'(bus.fetch_pc), 64'h0);

        bus.d_miss = 1'b1; bus.d_miss_trd = 3'd2; bus.d_miss_pc = 32'h40;
        bus.i_miss = 1'b1; bus.i_miss_trd = 3'd2; bus.i_miss_pc = 32'h50;
        bus.jmp    = 1'b1; bus.jmp_trd    = 3'd5; bus.jmp_pc    = 32'h80;
        tick(); idle();
        peek(2); check("dmiss_beats_imiss", 64'(bus.fetch_pc), 64'h40);
        peek(5); check("jmp_other_thread", 64'(bus.fetch_pc), 64'h80);

        peek(1);
        bus.stall = 1'b1; bus.i_rd = 1'b1;
        bus.jmp = 1'b1; bus.jmp_trd = 3'd1; bus.jmp_pc = 32'h99;
        tick();
        check("stall_holds", 64'(bus.fetch_pc), 64'h0);
        bus.d_miss = 1'b1; bus.d_miss_trd = 3'd1; bus.d_miss_pc = 32'h77;
        tick(); idle();
        check("stall_dmiss", 64'(bus.fetch_pc), 64'h77);

        bus.exp = 1'b1; bus.exp_trd = 3'd4; bus.exp_pc = 32'h1234;
        tick(); idle();
        peek(4);
        check("exp_pc", 64'(bus.fetch_pc), 64'h100);
        check("exp_mode4", 64'(bus.exp_mode[4]), 64'h1);
        check("exp_nodrop", 64'(bus.exp_drop), 64'h0);
        bus.exp = 1'b1; bus.exp_trd = 3'd4; bus.exp_pc = 32'h5555;
        tick(); idle();
        check("drop_pulse", 64'(bus.exp_drop), 64'h1);
        check("drop_pc", 64'(bus.fetch_pc), 64'h100);
        tick();
        check("drop_once", 64'(bus.exp_drop), 64'h0);
        bus.ret = 1'b1; bus.ret_trd = 3'd4;
        tick(); idle();
        check("ret_pc", 64'(bus.fetch_pc), 64'h1234);
        check("ret_mode4", 64'(bus.exp_mode[4]), 64'h0);

        bus.exp = 1'b1; bus.exp_trd = 3'd3; bus.exp_pc = 32'h10;
        bus.ret = 1'b1; bus.ret_trd = 3'd3;
        tick(); idle();
        peek(3);
        check("run_exp_wins_pc", 64'(bus.fetch_pc), 64'h100);
        check("run_exp_wins_mode", 64'(bus.exp_mode[3]), 64'h1);
        bus.exp = 1'b1; bus.exp_trd = 3'd3; bus.exp_pc = 32'h20;
        bus.ret = 1'b1; bus.ret_trd = 3'd3;
        tick(); idle();
        check("exc_ret_wins_pc", 64'(bus.fetch_pc), 64'h10);
        check("exc_ret_wins_mode", 64'(bus.exp_mode[3]), 64'h0);
        check("exc_ret_wins_drop", 64'(bus.exp_drop), 64'h1);

        bus.jmp = 1'b1; bus.jmp_trd = 3'd0; bus.jmp_pc = 32'hFFFF_FFFF;
        tick(); idle();
        peek(0);
        check("wrap_pre", 64'(bus.fetch_pc), 64'hFFFF_FFFF);
        bus.i_rd = 1'b1; bus.ret = 1'b1; bus.ret_trd = 3'd0;
        tick(); idle();
        check("wrap_zero", 64'(bus.fetch_pc), 64'h0);
        check("ret_in_run_mode", 64'(bus.exp_mode), 64'h0);

`ifdef PC_FILE_EXP_CNT_EN
        peek(6);
        for (int k = 0; k < 3; k++) begin
            bus.exp = 1'b1; bus.exp_trd = 3'd6; bus.exp_pc = 32'h300 + 32'(k);
            tick(); idle();
            check("cnt_after_exp", 64'(bus.exp_cnt), 64'h1);
            bus.ret = 1'b1; bus.ret_trd = 3'd6;
            tick(); idle();
            check("cnt_after_ret", 64'(bus.exp_cnt), 64'h0);
        end
        dut.r_cnt[6] = 8'hFF;
        m_cnt[6] = 8'hFF;
        bus.exp = 1'b1; bus.exp_trd = 3'd6; bus.exp_pc = 32'h400;
        tick(); idle();
        check("cnt_saturate", 64'(bus.exp_cnt), 64'hFF);
        bus.ret = 1'b1; bus.ret_trd = 3'd6;
        tick(); idle();
        check("cnt_sat_clear", 64'(bus.exp_cnt), 64'h0);
`endif

        bus.exp = 1'b1; bus.exp_trd = 3'd4; bus.exp_pc = 32'h1234;
        tick(); idle();
        peek(4);
        check("pre_rst_mode4", 64'(bus.exp_mode[4]), 64'h1);
        rst = 1'b1;
        #1;
        check("midrst_pc4", 64'(bus.fetch_pc), 64'(START));
        check("midrst_mode", 64'(bus.exp_mode), 64'h0);
        check("midrst_drop", 64'(bus.exp_drop), 64'h0);
        peek(2);
        check("midrst_pc2", 64'(bus.fetch_pc), 64'(START));
        tick();
        rst = 1'b0;
        tick();
        peek(5);
        check("post_rst_pc5", 64'(bus.fetch_pc), 64'(START));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_file.md
# pc_file

Parametrised per-thread program-counter file for the barrel-threaded core, the next generation of the fetch-stage PC selector. It holds one PC register, one exception-PC register and one run/exception mode bit per hardware thread. Each cycle it arbitrates among redirect sources: exception, return, D-miss replay, I-miss replay, jump and sequential increment. It supplies the PC for the thread selected by the fetch scheduler.

## Interface
Parameters:
- NUM_TRD, 8, number of hardware threads; must be a power of two, minimum 2.
- PC_W, 32, PC width in bits; PCs are word indices.
- START_PC, 0, reset value of every PC and EPC.
- HANDLER_PC, 32'h100, exception handler entry.
- TRD_W, $clog2(NUM_TRD), derived; must not be overridden.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- fetch_trd  in  TRD_W  thread being fetched this cycle.
- i_rd  in  1  fetch accepted; enables the sequential increment.
- stall  in  1  pipeline stall; blocks jump and increment only.
- fetch_pc  out  PC_W  current PC of fetch_trd.
- jmp / jmp_trd / jmp_pc  in  1/TRD_W/PC_W  taken branch or jump redirect.
- i_miss / i_miss_trd / i_miss_pc  in  1/TRD_W/PC_W  I-cache miss replay.
- d_miss / d_miss_trd / d_miss_pc  in  1/TRD_W/PC_W  D-cache miss replay.
- exp / exp_trd / exp_pc  in  1/TRD_W/PC_W  exception; exp_pc is the PC of the faulting instruction.
- ret / ret_trd  in  1/TRD_W  return-from-exception.
- exp_mode  out  NUM_TRD  per-thread mode bit; 1 means the thread is in the handler.
- exp_drop  out  1  registered one-cycle pulse for an exception ignored because the thread was already in the handler.
- exp_cnt  out  8  exception count of fetch_trd; present only with PC_FILE_EXP_CNT_EN.

## Operation
- Each thread runs a 2-state FSM: RUN (exp_mode=0) and EXC (exp_mode=1).
- Per-thread write priority, highest first; only the winning source writes:
  1. exp targeting the thread in RUN: pc←HANDLER_PC, epc←exp_pc, go to EXC.
  2. ret targeting the thread in EXC: pc←epc, go to RUN.
  3. d_miss: pc←d_miss_pc.
  4. i_miss: pc←i_miss_pc.
  5. jmp with !stall: pc←jmp_pc.
  6. fetch_trd match with i_rd and !stall: pc←pc+1.
- If nothing wins, pc holds.
- Sources aimed at different threads all act in the same cycle. Each thread resolves its priority independently.
- Exception arriving while the thread is in EXC:
  - pc, epc and mode are unchanged.
  - Lower-priority sources for that thread still apply.
  - exp_drop=1 on the next cycle.
- ret to a thread in RUN is ignored; lower-priority sources still apply.
- exp and ret are not gated by stall. Misses are not gated by stall.
- Increment is modulo 2^PC_W: all-ones wraps to 0.
- fetch_pc = pc[fetch_trd]; this is a combinational read of the registered state.

## Timing
- Reset values: every pc=START_PC, every epc=START_PC, exp_mode=0, exp_drop=0, exp_cnt=0.
- fetch_pc follows rst combinationally.
- Write latency is one cycle. A PC write in cycle N is visible on fetch_pc in cycle N+1.
- No same-cycle bypass: fetch_pc in cycle N shows the pre-write value.
- exp in cycle N: exp_mode[t]=1 and fetch_pc=HANDLER_PC from N+1.
- exp and ret to the same thread in the same cycle:
  - In RUN, exp wins.
  - In EXC, ret wins and exp_drop pulses.
- Reset asserted mid-operation clears all state immediately. Inputs are ignored while rst=1.
- The first write occurs on the first rising edge after rst deasserts.

## Configuration
- PC_FILE_EXP_CNT_EN defined:
  - Each thread has an 8-bit saturating counter.
  - The counter increments on every accepted exception (rule 1 only; dropped exceptions are not counted).
  - The counter saturates at 255 and is cleared by ret.
  - exp_cnt shows the counter of fetch_trd.
- PC_FILE_EXP_CNT_EN undefined: exp_cnt port and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then fetch_trd=3 with i_rd=1, stall=0 for 3 cycles -> fetch_pc 0,1,2; all other threads remain at 0.
- Same cycle: d_miss to thread 2 (pc=0x40), i_miss to thread 2 (pc=0x50), jmp to thread 5 (pc=0x80) -> next cycle pc[2]=0x40 and pc[5]=0x80.
- stall=1 with jmp and i_rd to thread 1 -> pc[1] holds. Same cycle with d_miss to thread 1 -> pc[1]=d_miss_pc.
- exp to thread 4 with exp_pc=0x1234 -> pc[4]=HANDLER_PC and exp_mode[4]=1. A second exp to thread 4 -> exp_drop pulses once and the stored return value is unchanged. ret to thread 4 -> pc[4]=0x1234 and exp_mode[4]=0.
- pc[0]=0xFFFFFFFF, fetch_trd=0, i_rd=1 -> pc[0]=0. ret to thread 0 while in RUN -> no effect beyond the increment.
- With PC_FILE_EXP_CNT_EN: 300 accepted exp/ret pairs without clearing ret are not possible, so instead:
  - 3 exps to thread 6 interleaved with rets -> exp_cnt reads 1 after each exp and 0 after each ret.
  - The saturation path is checked by forcing the counter to 255 -> it stays 255 after a further exp.
- Reset asserted mid-EXC -> all modes 0 and all PCs at START_PC immediately.
